// File: rtl/space_invaders_pkg.sv
// Shared Space Invaders definitions: direction and ship-movement state encodings,
// plus the playfield defaults shared by the ship controller, renderer and bullet logic.
package space_invaders_pkg;

  localparam int SHIP_COLUMNS = 20;
  localparam int SHIP_START_X = 5;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } ship_state_t;

  // Both buttons together cancel out to no movement.
  function automatic dir_t decode_dir(input logic left, input logic right);
    if (right && !left) return DIR_RIGHT;
    if (left && !right) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/ship_move_timer.sv
// Press-and-hold timing for the ship: emits a step strobe on the first press, after
// HOLD_TICKS qualifying ticks of holding, then every REPEAT_TICKS ticks.
module ship_move_timer
  import space_invaders_pkg::*;
#(
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic left,
  input  logic right,
  output logic step,
  output dir_t step_dir
);

  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ship_state_t      state_q, state_d;
  dir_t             prev_dir_q, prev_dir_d;
  dir_t             dir;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;

  always_comb begin
    dir        = decode_dir(left, right);
    cnt_dec    = cnt_q - CNT_W'(1);
    state_d    = state_q;
    prev_dir_d = prev_dir_q;
    cnt_d      = cnt_q;
    step       = 1'b0;
    step_dir   = dir;
    if (enable) begin
      prev_dir_d = dir;
      if (dir == DIR_NONE) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (dir != prev_dir_q || !(state_q == HOLD || state_q == REPEAT)) begin
        // New press or reversal: the FIRST step happens now, then the hold delay starts.
        step    = 1'b1;
        cnt_d   = CNT_W'(HOLD_TICKS);
        state_d = HOLD;
      end else if (cnt_dec == '0) begin
        step    = 1'b1;
        cnt_d   = CNT_W'(REPEAT_TICKS);
        state_d = REPEAT;
      end else begin
        cnt_d = cnt_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_dir_q <= DIR_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_dir_q <= prev_dir_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/ship_ctrl.sv
// Player-ship column register with boundary handling and registered limit/moved flags.
// Define SHIP_WRAP_EN to wrap around the playfield edges instead of saturating.
module ship_ctrl
  import space_invaders_pkg::*;
#(
  parameter int COLUMNS      = SHIP_COLUMNS,
  parameter int START_X      = SHIP_START_X,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  localparam int X_W         = $clog2(COLUMNS)
) (
  input  logic           clk_36MHz,
  input  logic           reset,
  input  logic           left_debounced,
  input  logic           right_debounced,
  input  logic           enable,
  output logic [X_W-1:0] ship_x,
  output logic           at_left_limit,
  output logic           at_right_limit,
  output logic           moved
);

  localparam logic [X_W-1:0] X_MAX   = X_W'(COLUMNS - 1);
  localparam logic [X_W-1:0] X_START = X_W'(START_X);

  logic           step;
  dir_t           step_dir;
  logic [X_W-1:0] ship_x_q, ship_x_d;
  logic           left_lim_q, left_lim_d;
  logic           right_lim_q, right_lim_d;
  logic           moved_q, moved_d;

  ship_move_timer #(
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_timer (
    .clk     (clk_36MHz),
    .reset   (reset),
    .enable  (enable),
    .left    (left_debounced),
    .right   (right_debounced),
    .step    (step),
    .step_dir(step_dir)
  );

  always_comb begin
    ship_x_d = ship_x_q;
    if (step) begin
      if (step_dir == DIR_RIGHT) begin
        if (ship_x_q == X_MAX) begin
`ifdef SHIP_WRAP_EN
          ship_x_d = '0;
`else
          ship_x_d = ship_x_q;
`endif
        end else begin
          ship_x_d = ship_x_q + X_W'(1);
        end
      end else if (step_dir == DIR_LEFT) begin
        if (ship_x_q == '0) begin
`ifdef SHIP_WRAP_EN
          ship_x_d = X_MAX;
`else
          ship_x_d = ship_x_q;
`endif
        end else begin
          ship_x_d = ship_x_q - X_W'(1);
        end
      end
    end
    // A step pinned against an edge leaves the position alone and does not count as a move.
    moved_d     = (ship_x_d != ship_x_q);
    left_lim_d  = (ship_x_d == '0);
    right_lim_d = (ship_x_d == X_MAX);
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      ship_x_q    <= X_START;
      left_lim_q  <= (X_START == '0);
      right_lim_q <= (X_START == X_MAX);
      moved_q     <= 1'b0;
    end else begin
      ship_x_q    <= ship_x_d;
      left_lim_q  <= left_lim_d;
      right_lim_q <= right_lim_d;
      moved_q     <= moved_d;
    end
  end

  assign ship_x         = ship_x_q;
  assign at_left_limit  = left_lim_q;
  assign at_right_limit = right_lim_q;
  assign moved          = moved_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// Bench for ship_ctrl: directed scenarios with literal expectations plus randomized
// button/enable/reset traffic compared every cycle against a tick-age reference model.
module tb_ship_ctrl;

  localparam int COLUMNS = 20;
  localparam int START_X = 5;
  localparam int HOLD    = 8;
  localparam int REP     = 2;

  logic       clk = 1'b0;
  logic       reset, left, right, enable;
  logic [4:0] ship_x;
  logic       atl, atr, moved;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ship_ctrl #(
    .COLUMNS(COLUMNS), .START_X(START_X), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) dut (
    .clk_36MHz      (clk),
    .reset          (reset),
    .left_debounced (left),
    .right_debounced(right),
    .enable         (enable),
    .ship_x         (ship_x),
    .at_left_limit  (atl),
    .at_right_limit (atr),
    .moved          (moved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age = enable ticks since the current direction was pressed.
  int m_x     = START_X;
  int m_prev  = 0;
  int m_age   = 0;
  bit m_moved = 1'b0;

  always @(posedge clk) begin
    int d, nx;
    bit st;
    if (reset) begin
      m_x = START_X; m_prev = 0; m_age = 0; m_moved = 1'b0;
    end else begin
      m_moved = 1'b0;
      if (enable) begin
        d  = (right && !left) ? 1 : ((left && !right) ? -1 : 0);
        st = 1'b0;
        if (d == 0) m_age = 0;
        else if (d != m_prev) begin m_age = 0; st = 1'b1; end
        else begin
          m_age++;
          st = (m_age == HOLD) || (m_age > HOLD && ((m_age - HOLD) % REP) == 0);
        end
        if (st) begin
          nx = m_x + d;
`ifdef SHIP_WRAP_EN
          if (nx < 0) nx = COLUMNS - 1;
          if (nx >= COLUMNS) nx = 0;
`else
          if (nx < 0) nx = 0;
          if (nx >= COLUMNS) nx = COLUMNS - 1;
`endif
          m_moved = (nx != m_x);
          m_x = nx;
        end
        m_prev = d;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ship_x", int'(ship_x), m_x);
      chk("model_left_limit", int'(atl), int'(m_x == 0));
      chk("model_right_limit", int'(atr), int'(m_x == COLUMNS - 1));
      chk("model_moved", int'(moved), int'(m_moved));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int hold_exp [0:15] = '{4, 4, 4, 4, 4, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; enable = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state and idle
    chk("reset_x", int'(ship_x), 5);
    chk("reset_left_lim", int'(atl), 0);
    chk("reset_right_lim", int'(atr), 0);
    chk("reset_moved", int'(moved), 0);
    enable = 1'b1;
    cyc(4);
    chk("idle_x", int'(ship_x), 5);
    chk("idle_moved", int'(moved), 0);

    // Single right tick
    right = 1'b1;
    cyc();
    chk("tap_x", int'(ship_x), 6);
    chk("tap_moved", int'(moved), 1);
    right = 1'b0;
    cyc();
    chk("tap_moved_drop", int'(moved), 0);
    cyc(5);
    chk("tap_settle_x", int'(ship_x), 6);

    // Hold left from 5 down to the limit
    do_reset();
    left = 1'b1;
    for (int t = 0; t < 16; t++) begin
      cyc();
      chk("hold_left_x", int'(ship_x), hold_exp[t]);
    end
    chk("hold_left_lim", int'(atl), 1);
    cyc();
`ifdef SHIP_WRAP_EN
    chk("edge_x", int'(ship_x), 19);
    chk("edge_moved", int'(moved), 1);
    chk("edge_right_lim", int'(atr), 1);
`else
    chk("edge_x", int'(ship_x), 0);
    chk("edge_moved", int'(moved), 0);
    chk("edge_left_lim", int'(atl), 1);
`endif
    left = 1'b0;

    // Both buttons, then release left
    do_reset();
    left = 1'b1; right = 1'b1;
    cyc(20);
    chk("both_x", int'(ship_x), 5);
    left = 1'b0;
    cyc();
    chk("release_x", int'(ship_x), 6);
    chk("release_moved", int'(moved), 1);
    right = 1'b0;

    // Reset mid-hold, then enable gating
    do_reset();
    right = 1'b1;
    cyc(5);
    chk("prehold_x", int'(ship_x), 6);
    do_reset();
    chk("midreset_x", int'(ship_x), 5);
    chk("midreset_moved", int'(moved), 0);
    cyc();
    chk("repress_x", int'(ship_x), 6);
    enable = 1'b0;
    cyc(10);
    chk("gated_x", int'(ship_x), 6);
    chk("gated_moved", int'(moved), 0);
    enable = 1'b1;
    right = 1'b0;

    // Randomized traffic, held buttons persist so hold/repeat and edges get exercised
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) left = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) right = $urandom_range(0, 1) == 1;
      enable = $urandom_range(0, 3) != 0;
      reset  = $urandom_range(0, 299) == 0;
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
